// File: rtl/matmul_seq_pkg.sv
// Shared types for the sequential matrix multiplier: instruction word and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package matmul_seq_pkg;

    // Operand BRAM read latency, in cycles, from rd_en to a_rdata/b_rdata.
    localparam int MEM_RD_LAT = 1;

    // One instruction: C[n x p] = A[n x m] * B[m x p]. n occupies the MSBs.
    typedef struct packed {
        logic [15:0] n;
        logic [15:0] m;
        logic [15:0] p;
    } inst_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_FIN
    } seq_state_e;

endpackage

// File: rtl/matmul_seq_mac.sv
// Signed multiply-accumulate fed by the operand BRAMs: acc = sum of sext(a)*sext(b).
// Latency: the operand pair read in cycle t is folded into acc at the end of cycle t+1.
// Backpressure: none; it accumulates whenever the delayed read strobe is high.
// Ports: rd_en/first_rd from the sequencer, a_rdata/b_rdata from the BRAMs, acc to the C port.
module matmul_seq_mac #(
    parameter int DW    = 16,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic             first_rd,
    input  logic [DW-1:0]    a_rdata,
    input  logic [DW-1:0]    b_rdata,
    output logic [ACC_W-1:0] acc
);

    logic                   mac_en;
    logic                   mac_first;
    logic signed [2*DW-1:0] prod;
    logic [ACC_W-1:0]       prod_ext;
    logic [ACC_W-1:0]       acc_base;

    assign prod     = $signed(a_rdata) * $signed(b_rdata);
    assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    // The k==0 read starts a new element, so its product replaces the old sum.
    assign acc_base = mac_first ? '0 : acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mac_en    <= 1'b0;
            mac_first <= 1'b0;
            acc       <= '0;
        end else begin
            // One-cycle delay lines track the fixed BRAM read latency.
            mac_en    <= rd_en;
            mac_first <= rd_en & first_rd;
            if (mac_en) begin
                acc <= acc_base + prod_ext;
            end
        end
    end

endmodule

// File: rtl/matmul_seq.sv
// Sequencer for C = A * B: walks i,j,k, reads A/B, accumulates, writes C row-major.
// Latency: 1 accept cycle + n*p*(m+2) + 1 FIN cycle per instruction.
// Backpressure: inst_ready is high only in IDLE; the C port is never stalled.
// Ports: inst/inst_valid/inst_ready handshake, a_addr/b_addr/rd_en + a_rdata/b_rdata reads,
//        c_addr/c_wdata/c_we writes, busy level and done completion pulse.
module matmul_seq
    import matmul_seq_pkg::*;
#(
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  inst_t            inst,
    input  logic             inst_valid,
    output logic             inst_ready,
    output logic [AW-1:0]    a_addr,
    output logic [AW-1:0]    b_addr,
    output logic             rd_en,
    input  logic [DW-1:0]    a_rdata,
    input  logic [DW-1:0]    b_rdata,
    output logic [AW-1:0]    c_addr,
    output logic [ACC_W-1:0] c_wdata,
    output logic             c_we,
    output logic             busy,
    output logic             done
);

    localparam logic [AW-1:0] A_ONE = AW'(1);

    seq_state_e    state, state_nx;
    logic [15:0]   n_r, m_r, p_r;
    logic [15:0]   i_r, j_r, k_r;
    logic [AW-1:0] a_row_base;
    logic          last_k, last_j, last_i;
    logic          zero_dim;

    assign last_k   = (k_r == m_r - 16'd1);
    assign last_j   = (j_r == p_r - 16'd1);
    assign last_i   = (i_r == n_r - 16'd1);
    assign zero_dim = (inst.n == 16'd0) || (inst.m == 16'd0) || (inst.p == 16'd0);

    always_comb begin
        state_nx   = state;
        inst_ready = 1'b0;
        rd_en      = 1'b0;
        c_we       = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                inst_ready = 1'b1;
                busy       = 1'b0;
                if (inst_valid) begin
                    state_nx = zero_dim ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                rd_en = 1'b1;
                if (last_k) begin
                    state_nx = S_DRAIN;
                end
            end
            // Last operand pair lands in the MAC this cycle.
            S_DRAIN: state_nx = S_WRITE;
            S_WRITE: begin
                c_we     = 1'b1;
                state_nx = (last_i && last_j) ? S_FIN : S_ISSUE;
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Addresses are running sums; no multipliers anywhere on the address path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            n_r        <= '0;
            m_r        <= '0;
            p_r        <= '0;
            i_r        <= '0;
            j_r        <= '0;
            k_r        <= '0;
            a_row_base <= '0;
            a_addr     <= '0;
            b_addr     <= '0;
            c_addr     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (inst_valid) begin
                        n_r        <= inst.n;
                        m_r        <= inst.m;
                        p_r        <= inst.p;
                        i_r        <= '0;
                        j_r        <= '0;
                        k_r        <= '0;
                        a_row_base <= '0;
                        a_addr     <= '0;
                        b_addr     <= '0;
                        c_addr     <= '0;
                    end
                end
                S_ISSUE: begin
                    a_addr <= a_addr + A_ONE;
                    b_addr <= b_addr + AW'(p_r);
                    k_r    <= last_k ? 16'd0 : k_r + 16'd1;
                end
                S_WRITE: begin
                    c_addr <= c_addr + A_ONE;
                    if (last_j) begin
                        // Row done: move A to the next row, B back to column 0.
                        j_r        <= '0;
                        i_r        <= i_r + 16'd1;
                        a_row_base <= a_row_base + AW'(m_r);
                        a_addr     <= a_row_base + AW'(m_r);
                        b_addr     <= '0;
                    end else begin
                        // Same row, next column: A rewinds to the row start.
                        j_r    <= j_r + 16'd1;
                        a_addr <= a_row_base;
                        b_addr <= AW'(j_r) + A_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    matmul_seq_mac #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .first_rd (k_r == 16'd0),
        .a_rdata  (a_rdata),
        .b_rdata  (b_rdata),
        .acc      (c_wdata)
    );

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq with a 1-cycle-latency A/B memory model and a C write log.
// Latency: n/a.
// Backpressure: n/a.
module tb_matmul_seq;
    import matmul_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    inst_t       inst = '0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [15:0] a_addr, b_addr, c_addr;
    logic        rd_en, c_we, busy, done;
    logic [15:0] a_rdata = '0;
    logic [15:0] b_rdata = '0;
    logic [47:0] c_wdata;

    logic signed [15:0] a_mem [0:63];
    logic signed [15:0] b_mem [0:63];

    int n_cmp = 0;
    int n_bad = 0;
    int rd_cnt = 0, we_cnt = 0, done_cnt = 0, busy_cnt = 0;
    logic [15:0] cw_addr [$];
    logic [47:0] cw_data [$];

    always #5 clk = ~clk;

    matmul_seq dut (
        .clk        (clk),
        .rst        (rst),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .a_addr     (a_addr),
        .b_addr     (b_addr),
        .rd_en      (rd_en),
        .a_rdata    (a_rdata),
        .b_rdata    (b_rdata),
        .c_addr     (c_addr),
        .c_wdata    (c_wdata),
        .c_we       (c_we),
        .busy       (busy),
        .done       (done)
    );

    // Synchronous BRAM model: data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            a_rdata <= a_mem[a_addr[5:0]];
            b_rdata <= b_mem[b_addr[5:0]];
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (rd_en) rd_cnt++;
            if (done) done_cnt++;
            if (busy && !done) busy_cnt++;
            if (c_we) begin
                we_cnt++;
                cw_addr.push_back(c_addr);
                cw_data.push_back(c_wdata);
            end
        end
    end

    task automatic clear_log();
        rd_cnt = 0; we_cnt = 0; done_cnt = 0; busy_cnt = 0;
        cw_addr.delete();
        cw_data.delete();
    endtask

    // Called at a negedge; returns #1 after the accepting posedge with inst_valid dropped.
    task automatic send(input logic [15:0] n, input logic [15:0] m, input logic [15:0] p);
        bit ok = 0;
        inst.n = n; inst.m = m; inst.p = p;
        inst_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (inst_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL accept: inst_ready never seen, required 1"); end
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        clear_log();
    endtask

    // Counts negedges after the accepting posedge until done; 0 means timeout.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (done) begin cyc = c; break; end
        end
        n_cmp++;
        if (cyc == 0) begin n_bad++; $display("FAIL done_timeout: no done within 300 cycles"); end
    endtask

    task automatic load_1to6();
        for (int x = 0; x < 64; x++) begin
            a_mem[x] = (x < 6) ? 16'(x + 1) : 16'sd0;
            b_mem[x] = (x < 6) ? 16'(x + 1) : 16'sd0;
        end
    endtask

    task automatic check_c_2x3x2(input string tag);
        logic [47:0] exp_c [4];
        exp_c = '{48'd22, 48'd28, 48'd49, 48'd64};
        n_cmp++;
        if (cw_data.size() != 4) begin
            n_bad++;
            $display("FAIL %s_nwrites: got %0d required 4", tag, cw_data.size());
        end else begin
            for (int e = 0; e < 4; e++) begin
                n_cmp++;
                if (cw_addr[e] !== 16'(e) || cw_data[e] !== exp_c[e]) begin
                    n_bad++;
                    $display("FAIL %s_c%0d: got addr %0d data %0d required addr %0d data %0d",
                             tag, e, cw_addr[e], cw_data[e], e, exp_c[e]);
                end
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (inst_ready !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0 || c_we !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: ready=%b busy=%b rd=%b we=%b done=%b required 1 0 0 0 0",
                     inst_ready, busy, rd_en, c_we, done);
        end
        @(negedge clk);
        rst = 1'b1;
        clear_log();
        repeat (10) @(negedge clk);
        n_cmp++;
        if (rd_cnt !== 0 || we_cnt !== 0 || inst_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_quiet: rd=%0d we=%0d ready=%b busy=%b required 0 0 1 0",
                     rd_cnt, we_cnt, inst_ready, busy);
        end
    endtask

    task automatic test_single();
        int cyc;
        a_mem[0] = 16'sd3;
        b_mem[0] = -16'sd4;
        send(16'd1, 16'd1, 16'd1);
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 4) begin n_bad++; $display("FAIL single_latency: got %0d required 4", cyc); end
        n_cmp++;
        if (cw_data.size() != 1 || cw_addr[0] !== 16'd0 || cw_data[0] !== 48'hFFFF_FFFF_FFF4) begin
            n_bad++;
            $display("FAIL single_c: writes %0d addr %0d data %0h required 1 0 fffffffffff4",
                     cw_data.size(), (cw_addr.size() > 0) ? cw_addr[0] : 16'hx,
                     (cw_data.size() > 0) ? cw_data[0] : 48'hx);
        end
    endtask

    task automatic test_2x3x2();
        int cyc;
        load_1to6();
        send(16'd2, 16'd3, 16'd2);
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 21) begin n_bad++; $display("FAIL mm_latency: got %0d required 21", cyc); end
        // 4 elements x (3 reads + drain + write) = 20 working cycles before FIN.
        n_cmp++;
        if (busy_cnt !== 20) begin n_bad++; $display("FAIL mm_busy: got %0d required 20", busy_cnt); end
        n_cmp++;
        if (rd_cnt !== 12) begin n_bad++; $display("FAIL mm_reads: got %0d required 12", rd_cnt); end
        check_c_2x3x2("mm");
    endtask

    task automatic test_zero_dim();
        int cyc;
        send(16'd3, 16'd0, 16'd2);
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 1) begin n_bad++; $display("FAIL zero_latency: got %0d required 1", cyc); end
        n_cmp++;
        if (rd_cnt !== 0 || we_cnt !== 0) begin
            n_bad++;
            $display("FAIL zero_traffic: rd=%0d we=%0d required 0 0", rd_cnt, we_cnt);
        end
        @(negedge clk);
        n_cmp++;
        if (inst_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready: got %b required 1", inst_ready); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        for (int x = 0; x < 64; x++) begin
            a_mem[x] = -16'sd32768;
            b_mem[x] = -16'sd32768;
        end
        send(16'd1, 16'd4, 16'd1);
        // Hold valid with the next instruction queued behind the running one.
        inst.n = 16'd1; inst.m = 16'd2; inst.p = 16'd1;
        inst_valid = 1'b1;
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 7) begin n_bad++; $display("FAIL b2b_latency: got %0d required 7", cyc); end
        @(negedge clk);
        n_cmp++;
        if (inst_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b required 1", inst_ready); end
        @(negedge clk);
        inst_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: busy %b required 1", busy); end
        wait_done(cyc);
        n_cmp++;
        if (cw_data.size() != 2 || cw_data[0] !== 48'h1_0000_0000 || cw_data[1] !== 48'h0_8000_0000) begin
            n_bad++;
            $display("FAIL b2b_c: writes %0d first %0h second %0h required 2 100000000 80000000",
                     cw_data.size(), (cw_data.size() > 0) ? cw_data[0] : 48'hx,
                     (cw_data.size() > 1) ? cw_data[1] : 48'hx);
        end
    endtask

    task automatic test_reset_abort();
        load_1to6();
        send(16'd2, 16'd3, 16'd2);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (rd_en !== 1'b0 || busy !== 1'b0 || c_we !== 1'b0 || done !== 1'b0 || inst_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_outputs: rd=%b busy=%b we=%b done=%b ready=%b required 0 0 0 0 1",
                     rd_en, busy, c_we, done, inst_ready);
        end
        n_cmp++;
        if (a_addr !== 16'd0 || b_addr !== 16'd0 || c_addr !== 16'd0) begin
            n_bad++;
            $display("FAIL abort_addrs: a=%0d b=%0d c=%0d required 0 0 0", a_addr, b_addr, c_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (done_cnt !== 0 || we_cnt !== 0) begin
            n_bad++;
            $display("FAIL abort_nodone: done=%0d we=%0d required 0 0", done_cnt, we_cnt);
        end
        begin
            int cyc;
            send(16'd2, 16'd3, 16'd2);
            wait_done(cyc);
        end
        check_c_2x3x2("rerun");
    endtask

    initial begin
        test_reset();
        test_single();
        test_2x3x2();
        test_zero_dim();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
